// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative read-only instruction cache with round-robin replacement and flush
module icache_assoc #(
    parameter int ADDRESS_BITWIDTH        = 32,
    parameter int DATA_BITWIDTH           = 32,
    parameter int WAYS_BITWIDTH           = 1,
    parameter int SET_IX_BITWIDTH         = 1,
    parameter int LINE_WORD_IX_BITWIDTH   = 3,
    parameter int RAM_DEPTH_BITWIDTH      = 8,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDRESS_BITWIDTH-1:0]          addr,
    output logic [DATA_BITWIDTH-1:0]             dout,
    output logic                                 rdy,
    output logic                                 bsy,
    input  logic                                 inv,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);
    localparam int WAYS     = 1 << WAYS_BITWIDTH;
    localparam int SETS     = 1 << SET_IX_BITWIDTH;
    localparam int WORDS    = 1 << LINE_WORD_IX_BITWIDTH;
    localparam int LW       = LINE_WORD_IX_BITWIDTH;
    localparam int PTR_W    = (WAYS_BITWIDTH > 0) ? WAYS_BITWIDTH : 1;
    localparam int SET_W    = (SET_IX_BITWIDTH > 0) ? SET_IX_BITWIDTH : 1;
    localparam int TAG_LSB  = 2 + LW + SET_IX_BITWIDTH;
    localparam int TAG_W    = ADDRESS_BITWIDTH - TAG_LSB;
    localparam int WPB      = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int BEAT_W   = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam int BYTE_SH  = $clog2(RAM_BURST_DATA_BITWIDTH / 8);
    localparam int BURST_SH = $clog2(RAM_BURST_DATA_COUNT);

    typedef enum logic [2:0] {S_LOOKUP, S_ISSUE, S_FILL, S_REPLAY, S_FLUSH} state_t;
    state_t r_state, w_next;

    logic                          r_rdy, r_bsy, r_cmd_en, r_flush_pend;
    logic [DATA_BITWIDTH-1:0]      r_dout;
    logic [RAM_DEPTH_BITWIDTH-1:0] r_br_addr, r_line_addr;
    logic [SET_W-1:0]              r_set;
    logic [TAG_W-1:0]              r_tag_l;
    logic [LW-1:0]                 r_word;
    logic [PTR_W-1:0]              r_victim;
    logic [BEAT_W-1:0]             r_beat;

    logic                     r_valid [WAYS][SETS];
    logic [PTR_W-1:0]         r_ptr   [SETS];
    logic [TAG_W-1:0]         r_tags  [WAYS][SETS];
    logic [DATA_BITWIDTH-1:0] r_data  [WAYS][SETS][WORDS];

    logic [ADDRESS_BITWIDTH-1:0]   w_set_bits;
    logic [SET_W-1:0]              w_set;
    logic [TAG_W-1:0]              w_tag;
    logic [LW-1:0]                 w_word;
    logic [RAM_DEPTH_BITWIDTH-1:0] w_line_addr;
    logic                          w_hit, w_have_free;
    logic [PTR_W-1:0]              w_hit_way, w_victim, w_ptr_next;
    logic [DATA_BITWIDTH-1:0]      w_hit_word, w_fill_word;
    logic                          w_do_lookup, w_do_flush, w_issue, w_beat_fire, w_last_beat;

    assign w_set_bits  = addr >> (2 + LW);
    assign w_set       = SET_W'(w_set_bits) & SET_W'(SETS - 1);
    assign w_tag       = TAG_W'(addr >> TAG_LSB);
    assign w_word      = LW'(addr >> 2);
    assign w_line_addr = RAM_DEPTH_BITWIDTH'((addr >> (BYTE_SH + BURST_SH)) << BURST_SH);
    assign w_hit_word  = r_data[w_hit_way][w_set][w_word];
    assign w_ptr_next  = (WAYS_BITWIDTH == 0) ? '0 : PTR_W'(r_ptr[r_set] + 1'b1);

    // Victim prefers the lowest invalid way; the round-robin pointer only decides among full sets.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_have_free = 1'b0;
        w_victim    = r_ptr[w_set];
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_set] && r_tags[w][w_set] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = PTR_W'(w);
            end
            if (!w_have_free && !r_valid[w][w_set]) begin
                w_have_free = 1'b1;
                w_victim    = PTR_W'(w);
            end
        end
    end

    // The requested word may sit in the beat arriving right now, which is not yet in the array.
    always_comb begin
        w_fill_word = r_data[r_victim][r_set][r_word];
        if ((int'(r_word) / WPB) == RAM_BURST_DATA_COUNT - 1)
            w_fill_word = br_rd_data[(int'(r_word) % WPB) * DATA_BITWIDTH +: DATA_BITWIDTH];
    end

    always_comb begin
        w_next      = r_state;
        w_do_lookup = 1'b0;
        w_do_flush  = 1'b0;
        w_issue     = 1'b0;
        w_beat_fire = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            S_LOOKUP: begin
                if (inv) begin
                    w_do_flush = 1'b1;
                    w_next     = S_FLUSH;
                end else begin
                    w_do_lookup = 1'b1;
                    if (!w_hit) w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!br_busy) begin
                    w_issue = 1'b1;
                    w_next  = S_FILL;
                end
            end
            S_FILL: begin
                if (br_rd_data_valid) begin
                    w_beat_fire = 1'b1;
                    if (r_beat == BEAT_W'(RAM_BURST_DATA_COUNT - 1)) begin
                        w_last_beat = 1'b1;
                        w_next      = S_REPLAY;
                    end
                end
            end
            S_REPLAY: begin
                if (inv || r_flush_pend) begin
                    w_do_flush = 1'b1;
                    w_next     = S_FLUSH;
                end else begin
                    w_do_lookup = 1'b1;
                    if (!w_hit) w_next = S_ISSUE;
                end
            end
            S_FLUSH: w_next = S_LOOKUP;
            default: w_next = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_LOOKUP;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy        <= 1'b0;
            r_bsy        <= 1'b0;
            r_dout       <= '0;
            r_cmd_en     <= 1'b0;
            r_br_addr    <= '0;
            r_line_addr  <= '0;
            r_flush_pend <= 1'b0;
            r_set        <= '0;
            r_tag_l      <= '0;
            r_word       <= '0;
            r_victim     <= '0;
            r_beat       <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
            end
        end else begin
            r_cmd_en <= w_issue;
            if (w_issue) r_br_addr <= r_line_addr;
            if (inv && (r_state == S_ISSUE || r_state == S_FILL)) r_flush_pend <= 1'b1;
            if (w_do_flush) begin
                for (int s = 0; s < SETS; s++) begin
                    r_ptr[s] <= '0;
                    for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
                end
                r_flush_pend <= 1'b0;
                r_rdy        <= 1'b0;
                r_bsy        <= 1'b1;
            end else if (w_do_lookup) begin
                if (w_hit) begin
                    r_rdy  <= 1'b1;
                    r_bsy  <= 1'b0;
                    r_dout <= w_hit_word;
                end else begin
                    r_rdy       <= 1'b0;
                    r_bsy       <= 1'b1;
                    r_set       <= w_set;
                    r_tag_l     <= w_tag;
                    r_word      <= w_word;
                    r_victim    <= w_victim;
                    r_line_addr <= w_line_addr;
                    r_beat      <= '0;
                end
            end else if (w_beat_fire) begin
                r_beat <= r_beat + 1'b1;
                if (w_last_beat) begin
                    r_valid[r_victim][r_set] <= 1'b1;
                    r_ptr[r_set]             <= w_ptr_next;
                    r_rdy                    <= 1'b1;
                    r_bsy                    <= 1'b0;
                    r_dout                   <= w_fill_word;
                end
            end else if (r_state == S_FLUSH) begin
                r_rdy <= 1'b0;
                r_bsy <= 1'b0;
            end else begin
                r_rdy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_beat_fire) begin
            for (int i = 0; i < WPB; i++)
                r_data[r_victim][r_set][LW'(int'(r_beat) * WPB + i)] <=
                    br_rd_data[i * DATA_BITWIDTH +: DATA_BITWIDTH];
        end
        if (!rst && w_last_beat) r_tags[r_victim][r_set] <= r_tag_l;
    end

    assign dout         = r_dout;
    assign rdy          = r_rdy;
    assign bsy          = r_bsy;
    assign br_cmd       = 1'b0;
    assign br_cmd_en    = r_cmd_en;
    assign br_addr      = r_br_addr;
    assign br_wr_data   = '0;
    assign br_data_mask = '0;
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed scoreboard bench for icache_assoc
module tb_icache_assoc;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst, inv, br_busy, br_rd_data_valid;
    logic [31:0] addr, dout;
    logic        rdy, bsy, br_cmd, br_cmd_en;
    logic [7:0]  br_addr, br_data_mask;
    logic [63:0] br_wr_data, br_rd_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  cmd_q[$];

    icache_assoc dut (
        .clk(clk), .rst(rst), .addr(addr), .dout(dout), .rdy(rdy), .bsy(bsy), .inv(inv),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BurstRAM model: 32-bit word at byte address a holds a>>2.
    initial begin
        forever begin
            @(negedge clk);
            if (br_cmd_en === 1'b1) begin
                chk("cmd_while_busy", br_busy, 0);
                cmd_q.push_back(br_addr);
            end
        end
    end

    initial begin
        logic [7:0] base;
        br_rd_data_valid = 1'b0;
        br_rd_data       = '0;
        forever begin
            @(negedge clk);
            if (cmd_q.size() > 0) begin
                base = cmd_q.pop_front();
                repeat (LAT - 1) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    br_rd_data = {32'(2 * (int'(base) + k) + 1), 32'(2 * (int'(base) + k))};
                    br_rd_data_valid = 1'b1;
                    @(negedge clk);
                end
                br_rd_data_valid = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit exp_hit, input logic [7:0] exp_br,
                         input int busy_cyc);
        int   cmds;
        logic got;
        logic [31:0] e;
        addr = a;
        exp_q.push_back(a >> 2);
        if (busy_cyc > 0) br_busy = 1'b1;
        @(posedge clk); #1;
        if (exp_hit) begin
            chk("hit_rdy", rdy, 1);
            chk("hit_bsy", bsy, 0);
            chk("hit_cmd_en", br_cmd_en, 0);
            e = exp_q.pop_front();
            chk("hit_dout", dout, e);
        end else begin
            chk("miss_bsy", bsy, 1);
            chk("miss_rdy", rdy, 0);
            cmds = 0;
            got  = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                if (busy_cyc > 0) begin
                    busy_cyc--;
                    if (busy_cyc == 0) br_busy = 1'b0;
                end
                @(posedge clk); #1;
                if (br_cmd_en) begin
                    cmds++;
                    chk("br_addr", br_addr, exp_br);
                end
                if (rdy) got = 1'b1;
                else     chk("fill_bsy", bsy, 1);
            end
            chk("miss_done", got, 1);
            chk("cmd_count", cmds, 1);
            chk("replay_bsy", bsy, 0);
            e = exp_q.pop_front();
            chk("replay_dout", dout, e);
        end
    endtask

    initial begin
        logic seen;
        rst = 1'b1; inv = 1'b0; br_busy = 1'b0; addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 0);
        chk("rst_bsy", bsy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cmd", br_cmd, 0);
        chk("rst_cmd_en", br_cmd_en, 0);
        chk("rst_br_addr", br_addr, 0);
        chk("wr_data_tie", br_wr_data, 0);
        chk("mask_tie", br_data_mask, 0);
        rst = 1'b0;

        fetch(32'h0, 0, 8'd0, 0);
        fetch(32'h4, 1, 8'd0, 0);
        fetch(32'h8, 1, 8'd0, 0);

        fetch(32'h40, 0, 8'd8, 0);
        fetch(32'h80, 0, 8'd16, 0);
        fetch(32'h40, 1, 8'd0, 0);
        fetch(32'hC0, 0, 8'd24, 0);
        fetch(32'h40, 0, 8'd8, 0);
        fetch(32'hC0, 1, 8'd0, 0);
        fetch(32'h0,  0, 8'd0, 0);
        fetch(32'h40, 1, 8'd0, 0);
        fetch(32'h80, 0, 8'd16, 0);
        fetch(32'h0,  1, 8'd0, 0);

        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        chk("flush_bsy", bsy, 1);
        chk("flush_rdy", rdy, 0);
        @(posedge clk); #1;
        fetch(32'h0, 0, 8'd0, 0);
        fetch(32'h0, 1, 8'd0, 0);

        addr = 32'h20;
        @(posedge clk); #1;
        chk("fi_miss_bsy", bsy, 1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #1;
            if (br_cmd_en) seen = 1'b1;
        end
        chk("fi_cmd_seen", seen, 1);
        chk("fi_br_addr", br_addr, 4);
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (rdy) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("fi_replay_rdy", seen, 1);
        chk("fi_replay_dout", dout, 32'h8);
        chk("fi_replay_bsy", bsy, 0);
        @(posedge clk); #1;
        chk("fi_flush_bsy", bsy, 1);
        chk("fi_flush_rdy", rdy, 0);
        @(posedge clk); #1;
        fetch(32'h20, 0, 8'd4, 0);

        fetch(32'h60, 0, 8'd12, 10);
        fetch(32'h64, 1, 8'd0, 0);

        addr = 32'hA0;
        @(posedge clk); #1;
        chk("rf_miss_bsy", bsy, 1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #1;
            if (br_rd_data_valid) seen = 1'b1;
        end
        chk("rf_beat_seen", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rf_rdy", rdy, 0);
        chk("rf_bsy", bsy, 0);
        chk("rf_cmd_en", br_cmd_en, 0);
        rst = 1'b0;
        fetch(32'hA0, 0, 8'd20, 0);
        fetch(32'hBC, 1, 8'd0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
